// File: rtl/ram4k_port_ctrl_pkg.sv
// Shared widths and FSM encoding for the 4K x 16 RAM port controller.
package ram4k_port_ctrl_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 13;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RSP  = 3'd4,
    ST_FILL = 3'd5
  } state_e;

endpackage

// File: rtl/ram4k_port_ctrl_if.sv
// Request, response and fill-control channels between a client and the RAM port controller.
interface ram4k_port_ctrl_if
  import ram4k_port_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [LEN_W-1:0]  fill_len;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
           fill_start, fill_base, fill_len, fill_value,
    input  req_ready, rsp_valid, rsp_data, fill_busy, fill_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
           fill_start, fill_base, fill_len, fill_value,
    output req_ready, rsp_valid, rsp_data, fill_busy, fill_done
  );
endinterface

// File: rtl/ram4k_port_ctrl_fill_counter.sv
// Fill address generator: holds the next address (wrapping) and the words still owed, including the one on the bus.
module ram4k_port_ctrl_fill_counter #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;

  // The base word goes straight onto the bus at load, so the counter starts one ahead.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= base_i + 1'b1;
      rem_q  <= len_i;
    end else if (step_i) begin
      addr_q <= addr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (rem_q == LEN_W'(1));
endmodule

// File: rtl/ram4k_port_ctrl.sv
// Front end for the 4K x 16 RAM: single read/write requests, backpressured read responses and a block-fill engine.
module ram4k_port_ctrl
  import ram4k_port_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  ram4k_port_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              fill_busy_q, fill_busy_d;
  logic              fill_done_q, fill_done_d;
  logic              cnt_load, cnt_step, cnt_last;
  logic [ADDR_W-1:0] cnt_addr;

  ram4k_port_ctrl_fill_counter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_fill_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .step_i (cnt_step),
    .base_i (bus.fill_base),
    .len_i  (bus.fill_len),
    .addr_o (cnt_addr),
    .last_o (cnt_last)
  );

  // A fill request in the same cycle as a request wins.
  assign bus.req_ready = (state_q == ST_IDLE) && !bus.fill_start && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      fill_busy_q <= fill_busy_d;
      fill_done_q <= fill_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.fill_start) begin
          state_d = (bus.fill_len == '0) ? ST_IDLE : ST_FILL;
        end else if (bus.req_valid) begin
          state_d = bus.req_we ? ST_WR : ST_RD1;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_RSP;
      ST_RSP:  if (bus.rsp_ready) state_d = ST_IDLE;
      ST_FILL: if (cnt_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    fill_busy_d = fill_busy_q;
    fill_done_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fill_start) begin
          if (bus.fill_len == '0) begin
            fill_done_d = 1'b1;
          end else begin
            ram_addr_d  = bus.fill_base;
            ram_wdata_d = bus.fill_value;
            ram_we_d    = 1'b1;
            fill_busy_d = 1'b1;
            cnt_load    = 1'b1;
          end
        end else if (bus.req_valid) begin
          ram_addr_d = bus.req_addr;
          if (bus.req_we) begin
            ram_wdata_d = bus.req_wdata;
            ram_we_d    = 1'b1;
          end
        end
      end
      ST_RD2: begin
        rsp_data_d  = ram_rdata;
        rsp_valid_d = 1'b1;
      end
      ST_RSP: if (bus.rsp_ready) rsp_valid_d = 1'b0;
      ST_FILL: begin
        // ram_wdata_q keeps the fill value loaded on entry for the whole burst.
        if (cnt_last) begin
          fill_busy_d = 1'b0;
          fill_done_d = 1'b1;
        end else begin
          ram_addr_d = cnt_addr;
          ram_we_d   = 1'b1;
          cnt_step   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.fill_busy = fill_busy_q;
  assign bus.fill_done = fill_done_q;
endmodule

// File: tb/tb_ram4k_port_ctrl.sv
// Directed bench for ram4k_port_ctrl driving a behavioural 4K x 16 RAM.
module tb_ram4k_port_ctrl;
  import ram4k_port_ctrl_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_we;

  ram4k_port_ctrl_if bus ();

  ram4k_port_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: 1-cycle read when we=0, write commits on the edge with data_out held.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i) ^ 16'h3C00;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int          cyc = 0;
  int          done_total = 0;
  logic [AW-1:0] wr_addrs [$];
  int          wr_cyc [$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      wr_addrs.push_back(ram_addr);
      wr_cyc.push_back(cyc);
    end
    if (bus.fill_done) done_total <= done_total + 1;
  end

  int tests = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 50 && !bus.req_ready; n++) tick();
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    check("wr_we", 32'(ram_we), 32'd1);
    check("wr_addr", 32'(ram_addr), 32'(addr));
    check("wr_data", 32'(ram_wdata), 32'(data));
    tick();
    check("wr_we_off", 32'(ram_we), 32'd0);
    check("wr_idle", 32'(bus.req_ready), 32'd1);
    $display("[TB] write addr=0x%03h data=0x%04h", addr, data);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input int hold);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = addr;
    bus.rsp_ready = 1'b0;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    check("rd_e0_valid", 32'(bus.rsp_valid), 32'd0);
    check("rd_e0_we", 32'(ram_we), 32'd0);
    tick();
    check("rd_e1_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("rd_e2_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd_data", 32'(bus.rsp_data), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rd_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("rd_hold_data", 32'(bus.rsp_data), 32'(exp));
      check("rd_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rd_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("rd_release_idle", 32'(bus.req_ready), 32'd1);
    $display("[TB] read addr=0x%03h expect=0x%04h hold=%0d", addr, exp, hold);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_fill_busy"}, 32'(bus.fill_busy), 32'd0);
    check({tag, "_fill_done"}, 32'(bus.fill_done), 32'd0);
  endtask

  task automatic start_fill(input logic [AW-1:0] base, input logic [12:0] len, input logic [DW-1:0] value);
    bus.fill_base  = base;
    bus.fill_len   = len;
    bus.fill_value = value;
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    $display("[TB] fill base=0x%03h len=%0d value=0x%04h", base, len, value);
  endtask

  initial begin
    int idx, d0, done_at;
    logic [AW-1:0] exp_addr;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.fill_start = 1'b0; bus.fill_base = '0;
    bus.fill_len = '0; bus.fill_value = '0;

    // Reset state
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    #1;
    check("post_reset_ready", 32'(bus.req_ready), 32'd1);

    // Write then read back, then read with backpressure
    do_write(12'h005, 16'h1234);
    do_read(12'h005, 16'h1234, 0);
    do_read(12'h005, 16'h1234, 5);

    // Wrapping fill across the top of the address space
    idx = wr_addrs.size();
    d0  = done_total;
    start_fill(12'hFFE, 13'd4, 16'hA5A5);
    check("fill_busy_on", 32'(bus.fill_busy), 32'd1);
    check("fill_ready_low", 32'(bus.req_ready), 32'd0);
    done_at = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.fill_done && done_at == 0) done_at = i;
    end
    check("fill_done_at", 32'(done_at), 32'd4);
    check("fill_done_count", 32'(done_total - d0), 32'd1);
    check("fill_busy_off", 32'(bus.fill_busy), 32'd0);
    check("fill_nwrites", 32'(wr_addrs.size() - idx), 32'd4);
    exp_addr = 12'hFFE;
    for (int k = 0; k < 4; k++) begin
      if (idx + k < wr_addrs.size()) begin
        check("fill_addr", 32'(wr_addrs[idx+k]), 32'(exp_addr));
        check("fill_consecutive", 32'(wr_cyc[idx+k] - wr_cyc[idx]), 32'(k));
      end
      exp_addr = exp_addr + 1'b1;
    end
    do_read(12'hFFE, 16'hA5A5, 0);
    do_read(12'hFFF, 16'hA5A5, 0);
    do_read(12'h000, 16'hA5A5, 0);
    do_read(12'h001, 16'hA5A5, 0);
    do_read(12'h002, 16'h3C02, 0);

    // Fill and request together: fill wins, request waits for fill_done
    idx = wr_addrs.size();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h005;
    bus.fill_base = 12'h100;
    bus.fill_len  = 13'd2;
    bus.fill_value = 16'h7777;
    bus.fill_start = 1'b1;
    #1;
    check("both_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.fill_start = 1'b0;
    check("both_e0_ready", 32'(bus.req_ready), 32'd0);
    check("both_e0_busy", 32'(bus.fill_busy), 32'd1);
    tick();
    check("both_e1_ready", 32'(bus.req_ready), 32'd0);
    check("both_e1_done", 32'(bus.fill_done), 32'd0);
    tick();
    check("both_e2_done", 32'(bus.fill_done), 32'd1);
    check("both_e2_ready", 32'(bus.req_ready), 32'd1);
    check("both_nwrites", 32'(wr_addrs.size() - idx), 32'd2);
    if (wr_addrs.size() - idx >= 2) begin
      check("both_addr0", 32'(wr_addrs[idx]), 32'h100);
      check("both_addr1", 32'(wr_addrs[idx+1]), 32'h101);
    end
    $display("[TB] fill+request collision base=0x100 len=2");
    do_read(12'h005, 16'h1234, 0);
    do_read(12'h101, 16'h7777, 0);

    // Zero-length fill
    idx = wr_addrs.size();
    d0  = done_total;
    start_fill(12'h300, 13'd0, 16'hDEAD);
    check("len0_done", 32'(bus.fill_done), 32'd1);
    check("len0_busy", 32'(bus.fill_busy), 32'd0);
    check("len0_we", 32'(ram_we), 32'd0);
    tick();
    check("len0_done_drop", 32'(bus.fill_done), 32'd0);
    check("len0_nwrites", 32'(wr_addrs.size() - idx), 32'd0);
    check("len0_done_count", 32'(done_total - d0), 32'd1);

    // Reset while in RD2
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h005;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("rst_rd2");
    reset = 1'b0;
    repeat (3) tick();
    check("rst_rd2_no_rsp", 32'(bus.rsp_valid), 32'd0);
    $display("[TB] reset during read (RD2)");

    // Reset mid-fill: two of eight words written
    idx = wr_addrs.size();
    d0  = done_total;
    start_fill(12'h200, 13'd8, 16'hBEEF);
    tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("rst_fill");
    reset = 1'b0;
    repeat (10) tick();
    check("rst_fill_nwrites", 32'(wr_addrs.size() - idx), 32'd2);
    check("rst_fill_no_done", 32'(done_total - d0), 32'd0);
    check("rst_fill_busy", 32'(bus.fill_busy), 32'd0);
    $display("[TB] reset during fill after 2 words");
    do_read(12'h200, 16'hBEEF, 0);
    do_read(12'h201, 16'hBEEF, 0);
    do_read(12'h202, 16'h3E02, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d errors=%0d", tests, errors);
    $fatal(1);
  end
endmodule
